mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_pkg.sv | 56 +++++
 rtl/mc_alu_decoder.sv | 27 ++
 rtl/mc_control_fsm.sv | 155 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// Optional jump support is enabled by defining MC_JUMP_EN.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB
`ifdef MC_JUMP_EN
        , S_JUMP
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_DIV = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU operation decoder.
// Unknown funct codes fall back to ADD and drop valid.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       valid
);

    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        unique case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_NOR:  alu_control = ALU_NOR;
            FN_MUL:  alu_control = ALU_MUL;
            FN_DIV:  alu_control = ALU_DIV;
            default: valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit (Moore FSM).
// Define MC_JUMP_EN to add the j instruction.
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    logic [2:0] fn_ctl;
    logic       fn_valid;
    logic       pc_write;
    logic       branch;

    mc_alu_decoder u_alu_dec (
        .funct       (funct),
        .alu_control (fn_ctl),
        .valid       (fn_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    unique case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXEC;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
`ifdef MC_JUMP_EN
                        OP_J:         state <= S_JUMP;
`endif
                        default: begin
                            state      <= S_FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: state <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state <= S_MEMWB;
                S_EXEC: begin
                    state <= S_ALUWB;
                    if (!fn_valid)
                        illegal_op <= 1'b1;
                end
                S_ADDIEX: state <= S_ADDIWB;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        alu_control = ALU_ADD;
        pc_src      = PCSRC_ALU;
        instr_done  = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
            end
            S_DECODE: alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = fn_ctl;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                branch      = 1'b1;
                pc_src      = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
        // Reset holds FETCH muxing but must never let a write through.
        if (!rst_n) begin
            pc_write   = 1'b0;
            branch     = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign pc_en = pc_write | (branch & zero);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm against a per-instruction trace model.
// Build with MC_JUMP_EN to match a DUT built with jump support.
`timescale 1ns/100ps
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pc_en, iord, ir_write, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .ir_write(ir_write),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en, iord, ir_write, mem_write, reg_write;
        logic       reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
        logic       instr_done, illegal_op;
    } obs_t;

    obs_t got;
    assign got = {pc_en, iord, ir_write, mem_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
                  instr_done, illegal_op};

    localparam int CL_LW = 0, CL_SW = 1, CL_RT = 2, CL_BEQ = 3;
    localparam int CL_ADDI = 4, CL_J = 5, CL_ILL = 6;

    int passed = 0;
    int total  = 0;
    bit m_ill  = 1'b0;
    logic [5:0] fn_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                               6'h2a, 6'h27, 6'h18, 6'h1a};
    logic [2:0] alu_tab [8] = '{3'b010, 3'b110, 3'b000, 3'b001,
                                3'b111, 3'b100, 3'b011, 3'b101};

    function automatic int cls_of(input logic [5:0] o);
        case (o)
            6'b100011: return CL_LW;
            6'b101011: return CL_SW;
            6'b000000: return CL_RT;
            6'b000100: return CL_BEQ;
            6'b001000: return CL_ADDI;
`ifdef MC_JUMP_EN
            6'b000010: return CL_J;
`endif
            default:   return CL_ILL;
        endcase
    endfunction

    function automatic int lat(input int c);
        case (c)
            CL_LW:   return 5;
            CL_SW, CL_RT, CL_ADDI: return 4;
            CL_BEQ, CL_J: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] f);
        for (int i = 0; i < 8; i++)
            if (fn_tab[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        for (int i = 0; i < 8; i++)
            if (fn_tab[i] == f) return alu_tab[i];
        return 3'b010;
    endfunction

    // Expected outputs for cycle k of an instruction of class c.
    function automatic obs_t model(input int c, input int k,
                                   input logic [5:0] f, input logic z,
                                   input bit ill);
        obs_t e = '0;
        e.alu_control = 3'b010;
        e.illegal_op  = ill;
        if (k == 0) begin
            e.ir_write  = 1'b1;
            e.pc_en     = 1'b1;
            e.alu_src_b = 2'b01;
        end else if (k == 1) begin
            e.alu_src_b = 2'b11;
        end else if ((c == CL_LW || c == CL_SW) && k == 2) begin
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
        end else if (c == CL_LW && k == 3) begin
            e.iord = 1'b1;
        end else if (c == CL_LW) begin
            e.mem_to_reg = 1'b1;
            e.reg_write  = 1'b1;
            e.instr_done = 1'b1;
        end else if (c == CL_SW) begin
            e.iord       = 1'b1;
            e.mem_write  = 1'b1;
            e.instr_done = 1'b1;
        end else if (c == CL_RT && k == 2) begin
            e.alu_src_a   = 1'b1;
            e.alu_control = fn_alu(f);
        end else if (c == CL_RT) begin
            e.reg_dst    = 1'b1;
            e.reg_write  = 1'b1;
            e.instr_done = 1'b1;
        end else if (c == CL_BEQ) begin
            e.alu_src_a   = 1'b1;
            e.alu_control = 3'b110;
            e.pc_src      = 2'b01;
            e.pc_en       = z;
            e.instr_done  = 1'b1;
        end else if (c == CL_ADDI && k == 2) begin
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'b10;
        end else if (c == CL_ADDI) begin
            e.reg_write  = 1'b1;
            e.instr_done = 1'b1;
        end else if (c == CL_J) begin
            e.pc_en      = 1'b1;
            e.pc_src     = 2'b10;
            e.instr_done = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t reset_exp();
        obs_t e = model(CL_ILL, 0, 6'h0, 1'b0, 1'b0);
        e.ir_write = 1'b0;
        e.pc_en    = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input obs_t exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic do_reset_pulse(input string tag);
        #1 rst_n = 1'b0;
        m_ill = 1'b0;
        #1 check({tag, "_in_reset"}, reset_exp());
        rst_n = 1'b1;
        #1 check({tag, "_released"}, model(CL_ILL, 0, 6'h0, 1'b0, 1'b0));
    endtask

    // Called shortly after a rising edge with the DUT in FETCH.
    // abort_k >= 0 pulses reset during that cycle of the instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int abort_k);
        int c = cls_of(o);
        logic z;
        string tag;
        for (int k = 0; k < lat(c); k++) begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            op = o;
            funct = f;
            zero = z;
            tag = $sformatf("op%02h_fn%02h_k%0d", o, f, k);
            if (k == abort_k) begin
                check({tag, "_pre"}, model(c, k, f, z, m_ill));
                do_reset_pulse(tag);
                return;
            end
            @(negedge clk);
            check(tag, model(c, k, f, z, m_ill));
            if (c == CL_ILL && k == 1) m_ill = 1'b1;
            if (c == CL_RT && k == 2 && !fn_ok(f)) m_ill = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ro, rf;
        int sel;
        #3 check("reset_async", reset_exp());
        @(posedge clk);
        #2 check("reset_held", reset_exp());
        rst_n = 1'b1;
        run_instr(6'b100011, 6'h00, 2, -1);
        run_instr(6'b000000, 6'b100010, 2, -1);
        run_instr(6'b000100, 6'h00, 1, -1);
        run_instr(6'b000100, 6'h00, 0, -1);
        run_instr(6'b001000, 6'h00, 2, -1);
        run_instr(6'b101011, 6'h00, 2, -1);
        run_instr(6'b111111, 6'h00, 2, -1);
        run_instr(6'b100011, 6'h00, 2, -1);
        run_instr(6'b111111, 6'h00, 2, -1);
        run_instr(6'b101011, 6'h00, 2, 3);
        run_instr(6'b000010, 6'h00, 2, -1);
        run_instr(6'b000000, 6'b111110, 2, -1);
        run_instr(6'b000000, 6'b011010, 2, -1);
        run_instr(6'b100011, 6'h00, 2, 2);
        for (int n = 0; n < 120; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: ro = 6'b100011;
                1: ro = 6'b101011;
                2: ro = 6'b000000;
                3: ro = 6'b000100;
                4: ro = 6'b001000;
                5: ro = 6'b000010;
                default: ro = 6'($urandom);
            endcase
            rf = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 7)]
                                              : 6'($urandom);
            if ($urandom_range(0, 14) == 0)
                run_instr(ro, rf, 2, $urandom_range(0, lat(cls_of(ro)) - 1));
            else
                run_instr(ro, rf, 2, -1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
